calc_feeder: RTL and testbench

- Operand dispatcher that sits directly upstream of the three-operand calc stage.
- Accepts complete {A,B,C} triples on a single push/stop input port and buffers them in a DEPTH-entry FIFO.
- Delivers each head triple to the calc stage's three independent push/stop channels, tracking per channel which operands have already transferred.
- Retires an entry only after all three channels have transferred; sustains one triple per cycle when no stop is asserted.

---
 rtl/calc_pkg.sv | 13 +
 rtl/calc_triple_fifo.sv | 61 ++++++
 rtl/calc_feeder.sv | 94 +++++++++
 tb/tb_calc_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calc operand path: default operand width and
// the packed {a,b,c} triple exchanged between the feeder and the calc stage.
package calc_pkg;

  localparam int CALC_W = 32;

  typedef struct packed {
    logic [CALC_W-1:0] a;
    logic [CALC_W-1:0] b;
    logic [CALC_W-1:0] c;
  } calc_triple_t;

endpackage

// File: rtl/calc_triple_fifo.sv
// Small circular buffer for operand triples. It holds storage, read/write
// pointers and occupancy. Writes into a full buffer and reads from an
// empty buffer are ignored, so the caller cannot corrupt the pointers.
module calc_triple_fifo
  import calc_pkg::*;
#(
  parameter int TW    = 3 * CALC_W,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn_i,
  input  logic [TW-1:0] wrData_i,
  input  logic          rdEn_i,
  output logic [TW-1:0] rdData_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [TW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          doWr, doRd;

  assign full_o   = (level_q == LW'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign level_o  = level_q;
  assign rdData_o = mem_q[rptr_q];

  // Qualify requests and compute next pointers and occupancy; the pointers wrap naturally.
  always_comb begin
    doWr    = wrEn_i & ~full_o;
    doRd    = rdEn_i & ~empty_o;
    wptr_d  = wptr_q + PW'(doWr);
    rptr_d  = rptr_q + PW'(doRd);
    level_d = level_q + LW'(doWr) - LW'(doRd);
  end

  // Storage needs no reset because the head is only looked at when level is nonzero.
  always_ff @(posedge clk) begin
    if (doWr) mem_q[wptr_q] <= wrData_i;
  end

  // Pointer and occupancy registers. Reset empties the buffer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/calc_feeder.sv
// Operand dispatcher for the three-operand calc stage. It buffers whole
// triples and presents the head entry on three independent push/stop
// channels. It remembers which channels have already taken their operand
// and retires the head once all three have transferred.
module calc_feeder
  import calc_pkg::*;
#(
  parameter int W     = CALC_W,
  parameter int DEPTH = 4,
  parameter int CW    = 16,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  inA,
  input  logic [W-1:0]  inB,
  input  logic [W-1:0]  inC,
  input  logic          pushIn,
  output logic          stopIn,
  output logic [W-1:0]  A,
  output logic [W-1:0]  B,
  output logic [W-1:0]  C,
  output logic          pushA,
  output logic          pushB,
  output logic          pushC,
  input  logic          stopA,
  input  logic          stopB,
  input  logic          stopC,
  output logic [LW-1:0] level,
  output logic [CW-1:0] retired,
  output logic          overflow
);

  localparam int TW = 3 * W;

  logic [TW-1:0] headData;
  logic          fifoFull, fifoEmpty;
  logic          enq, retire;
  logic [2:0]    sent_q, sent_d;
  logic [2:0]    offer, xfer, stopVec;
  logic [CW-1:0] retired_q, retired_d;
  logic          overflow_q, overflow_d;

  calc_triple_fifo #(
    .TW    (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wrEn_i   (enq),
    .wrData_i ({inA, inB, inC}),
    .rdEn_i   (retire),
    .rdData_o (headData),
    .level_o  (level),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

  assign stopIn = fifoFull;
  assign enq    = pushIn & ~fifoFull;

  assign A = fifoEmpty ? '0 : headData[3*W-1:2*W];
  assign B = fifoEmpty ? '0 : headData[2*W-1:W];
  assign C = fifoEmpty ? '0 : headData[W-1:0];

  assign {pushA, pushB, pushC} = offer;
  assign retired  = retired_q;
  assign overflow = overflow_q;

  // Channel bookkeeping (bit 2 = A, bit 1 = B, bit 0 = C). The head retires once every channel has taken its operand.
  always_comb begin
    stopVec    = {stopA, stopB, stopC};
    offer      = {3{~fifoEmpty}} & ~sent_q;
    xfer       = offer & ~stopVec;
    retire     = ((sent_q | xfer) == 3'b111);
    sent_d     = retire ? 3'b000 : (sent_q | xfer);
    retired_d  = retired_q + CW'(retire);
    overflow_d = overflow_q | (pushIn & fifoFull);
  end

  // Sent flags, retired counter and sticky overflow. Reset drops any partially sent head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q     <= 3'b000;
      retired_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sent_q     <= sent_d;
      retired_q  <= retired_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_calc_feeder.sv
// Directed self-checking bench for calc_feeder. Inputs change just after
// the rising edge, and outputs are checked before the next rising edge.
module tb_calc_feeder;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  inA, inB, inC;
  logic          pushIn;
  logic          stopIn;
  logic [W-1:0]  A, B, C;
  logic          pushA, pushB, pushC;
  logic          stopA, stopB, stopC;
  logic [LW-1:0] level;
  logic [CW-1:0] retired;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  calc_feeder #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .inA      (inA),
    .inB      (inB),
    .inC      (inC),
    .pushIn   (pushIn),
    .stopIn   (stopIn),
    .A        (A),
    .B        (B),
    .C        (C),
    .pushA    (pushA),
    .pushB    (pushB),
    .pushC    (pushC),
    .stopA    (stopA),
    .stopB    (stopB),
    .stopC    (stopC),
    .level    (level),
    .retired  (retired),
    .overflow (overflow)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs and let the combinational outputs settle
  task automatic applyStimulus(input logic push, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [2:0] stops);
    pushIn = push;
    inA    = a;
    inB    = b;
    inC    = c;
    {stopA, stopB, stopC} = stops;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected head order for the drain after the full-FIFO tests
  int drainOrder [4] = '{2, 3, 4, 8};

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 3'b000);
    #10;
    // Reset state
    checkOutput("rst_level",    level,    0);
    checkOutput("rst_stopIn",   stopIn,   0);
    checkOutput("rst_push",     {pushA, pushB, pushC}, 0);
    checkOutput("rst_A",        A,        0);
    checkOutput("rst_retired",  retired,  0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Single triple, stops low: offered the cycle after the push, retires immediately
    applyStimulus(1'b1, 2, 3, 4, 3'b000);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 3'b000);
    checkOutput("t1_push",  {pushA, pushB, pushC}, 3'b111);
    checkOutput("t1_A",     A, 2);
    checkOutput("t1_B",     B, 3);
    checkOutput("t1_C",     C, 4);
    checkOutput("t1_level", level, 1);
    tick();
    checkOutput("t1_retired", retired, 1);
    checkOutput("t1_level0",  level, 0);
    checkOutput("t1_pushA0",  pushA, 0);
    checkOutput("t1_A0",      A, 0);

    // B held off for three cycles while A and C transfer in the first cycle
    applyStimulus(1'b1, 5, 6, 7, 3'b010);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 3'b010);
    checkOutput("t2_c1_push", {pushA, pushB, pushC}, 3'b111);
    checkOutput("t2_c1_B",    B, 6);
    tick();
    checkOutput("t2_c2_push", {pushA, pushB, pushC}, 3'b010);
    checkOutput("t2_c2_B",    B, 6);
    checkOutput("t2_c2_lvl",  level, 1);
    tick();
    checkOutput("t2_c3_push", {pushA, pushB, pushC}, 3'b010);
    checkOutput("t2_c3_ret",  retired, 1);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 3'b000);
    checkOutput("t2_c4_pushB", pushB, 1);
    checkOutput("t2_c4_ret",   retired, 1);
    tick();
    checkOutput("t2_ret",   retired, 2);
    checkOutput("t2_level", level, 0);
    checkOutput("t2_pushB", pushB, 0);

    // Fill the FIFO with all stops high, then overflow it
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, W'(k), W'(k), W'(k), 3'b111);
      tick();
    end
    checkOutput("t3_level",  level, 4);
    checkOutput("t3_stopIn", stopIn, 1);
    checkOutput("t3_ovf0",   overflow, 0);
    checkOutput("t3_headA",  A, 1);
    applyStimulus(1'b1, 5, 5, 5, 3'b111);
    tick();
    checkOutput("t3_ovf1",   overflow, 1);
    checkOutput("t3_level4", level, 4);

    // Full FIFO: retire and a push in the same cycle; the push is rejected
    applyStimulus(1'b1, 6, 6, 6, 3'b000);
    checkOutput("t4_headA",   A, 1);
    checkOutput("t4_stopIn1", stopIn, 1);
    tick();
    checkOutput("t4_level3",  level, 3);
    checkOutput("t4_stopIn0", stopIn, 0);
    checkOutput("t4_headA2",  A, 2);
    checkOutput("t4_retired", retired, 3);
    applyStimulus(1'b1, 8, 8, 8, 3'b111);
    tick();
    checkOutput("t4_level4",  level, 4);

    // Drain in order 2,3,4,8 (6 was rejected)
    applyStimulus(1'b0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d_A", i), A, drainOrder[i]);
      checkOutput($sformatf("drain%0d_B", i), B, drainOrder[i]);
      tick();
    end
    checkOutput("drain_level",   level, 0);
    checkOutput("drain_retired", retired, 7);
    checkOutput("drain_ovf",     overflow, 1);

    // Ten back-to-back triples with stops low, wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, W'(10 + i), W'(110 + i), W'(210 + i), 3'b000);
      if (i > 0) begin
        checkOutput($sformatf("b2b%0d_A", i), A, 10 + i - 1);
        checkOutput($sformatf("b2b%0d_C", i), C, 210 + i - 1);
        checkOutput($sformatf("b2b%0d_lvl", i), level, 1);
      end
      tick();
    end
    applyStimulus(1'b0, 0, 0, 0, 3'b000);
    checkOutput("b2b_lastA", A, 19);
    tick();
    checkOutput("b2b_retired", retired, 17);
    checkOutput("b2b_level",   level, 0);

    // Asynchronous reset while the head has only A sent and two entries are queued
    applyStimulus(1'b1, 20, 120, 220, 3'b111);
    tick();
    applyStimulus(1'b1, 21, 121, 221, 3'b111);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 3'b011);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 3'b111);
    checkOutput("t6_partial", {pushA, pushB, pushC}, 3'b011);
    checkOutput("t6_level2",  level, 2);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_push",  {pushA, pushB, pushC}, 0);
    checkOutput("t6_rst_A",     A, 0);
    checkOutput("t6_rst_level", level, 0);
    checkOutput("t6_rst_ret",   retired, 0);
    checkOutput("t6_rst_ovf",   overflow, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 9, 9, 9, 3'b111);
    tick();
    applyStimulus(1'b0, 0, 0, 0, 3'b000);
    checkOutput("t6_fresh_push", {pushA, pushB, pushC}, 3'b111);
    checkOutput("t6_fresh_A",    A, 9);
    checkOutput("t6_fresh_lvl",  level, 1);
    tick();
    checkOutput("t6_fresh_ret",  retired, 1);
    checkOutput("t6_fresh_lvl0", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
